// File: rtl/cpu_defs.sv
// Shared constants and fetch state encodings for the MIPS core.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cpu_defs;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] IMEM_LO    = 32'h0000_3000;
    localparam logic [31:0] IMEM_HI    = 32'h0000_4FFC;

    localparam logic [4:0]  EXC_ADEL   = 5'd4;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,   // request outstanding, or a bad address reported in place
        S_HOLD  = 2'd1,   // instruction captured while the pipe is stalled
        S_DROP  = 2'd2    // waiting out a response made stale by exc/eret
    } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC priority mux (exc > eret > redirect > PC+4) and fetch address check.
// Latency: purely combinational.
// Backpressure: none; the caller decides when next_pc is loaded.
module fetch_next_pc
    import cpu_defs::*;
(
    input  logic [31:0] pc,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] next_pc,
    output logic        bad_addr
);

    // Select the next PC by fixed priority.
    always_comb begin
        next_pc = pc + 32'd4;
        if (exc_req) begin
            next_pc = EXC_VECTOR;
        end else if (eret_req) begin
            next_pc = epc;
        end else if (redirect_valid) begin
            next_pc = redirect_pc;
        end
    end

    // Misaligned or outside the instruction memory window.
    always_comb begin
        bad_addr = (pc[1:0] != 2'b00) || (pc < IMEM_LO) || (pc > IMEM_HI);
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, fetches over req/ready, presents Instr/PC/PC4/PC8 to IF/ID.
// Latency: zero-wait memory gives the instruction in the request cycle (bypass).
// Backpressure: en=0 parks a returned word in a hold buffer; req/addr held until ready.
module fetch_unit
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr_IF,
    output logic [31:0] PC_IF,
    output logic [31:0] PC4_IF,
    output logic [31:0] PC8_IF,
    output logic [4:0]  ExcCode_IF
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc_q;
    logic [31:0]  hold_q;
    logic [31:0]  drop_addr_q;

    logic [31:0]  pc_next;
    logic         bad_addr;
    logic         kill;
    logic         inst_vld;
    logic [31:0]  inst_dat;
    logic [4:0]   exc_code;
    logic         outstanding;
    logic         hold_cap;
    logic         fire;

    fetch_next_pc u_next_pc (
        .pc             (pc_q),
        .exc_req        (exc_req),
        .eret_req       (eret_req),
        .epc            (epc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .next_pc        (pc_next),
        .bad_addr       (bad_addr)
    );

    assign kill = exc_req | eret_req;
    assign fire = inst_vld & en;

    // FSM next state, memory request and presented instruction.
    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        imem_addr   = pc_q;
        inst_vld    = 1'b0;
        inst_dat    = 32'd0;
        exc_code    = 5'd0;
        outstanding = 1'b0;
        hold_cap    = 1'b0;
        case (state)
            S_FETCH: begin
                if (bad_addr) begin
                    // Reported in place; no memory access is made.
                    inst_vld = 1'b1;
                    exc_code = EXC_ADEL;
                end else begin
                    imem_req    = 1'b1;
                    outstanding = !imem_ready;
                    if (imem_ready) begin
                        inst_vld = 1'b1;
                        inst_dat = imem_rdata;
                        if (!en) begin
                            hold_cap  = 1'b1;
                            state_nxt = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                inst_vld = 1'b1;
                inst_dat = hold_q;
                if (en) begin
                    state_nxt = S_FETCH;
                end
            end
            S_DROP: begin
                // Keep the abandoned request stable until memory answers it.
                imem_req    = 1'b1;
                imem_addr   = drop_addr_q;
                outstanding = !imem_ready;
                if (imem_ready) begin
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
        if (kill) begin
            state_nxt = outstanding ? S_DROP : S_FETCH;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // PC advances on fire; exc/eret reload it unconditionally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else if (kill || fire) begin
            pc_q <= pc_next;
        end
    end

    // Hold buffer captures a word returned during a stall; flushed by exc/eret.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= 32'd0;
        end else if (kill) begin
            hold_q <= 32'd0;
        end else if (hold_cap) begin
            hold_q <= imem_rdata;
        end
    end

    // Remember the address of a request abandoned by exc/eret.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_addr_q <= RESET_PC;
        end else if (kill && outstanding && (state == S_FETCH)) begin
            drop_addr_q <= pc_q;
        end
    end

    assign Instr_IF   = kill ? 32'd0 : inst_dat;
    assign ExcCode_IF = exc_code;
    assign PC_IF      = pc_q;
    assign PC4_IF     = pc_q + 32'd4;
    assign PC8_IF     = pc_q + 32'd8;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, reset corner, random vs model.
// Latency: inputs driven 1 ns after posedge, outputs sampled 4 ns after posedge.
// Backpressure: bench memory only answers while a request is expected.
module tb_fetch_unit;

    localparam logic [31:0] T_RESET = 32'h0000_3000;
    localparam logic [31:0] T_VEC   = 32'h0000_4180;
    localparam logic [31:0] T_LO    = 32'h0000_3000;
    localparam logic [31:0] T_HI    = 32'h0000_4FFC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        exc_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] Instr_IF, PC_IF, PC4_IF, PC8_IF;
    logic [4:0]  ExcCode_IF;

    int n_pass = 0;
    int n_total = 0;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_req        (exc_req),
        .eret_req       (eret_req),
        .epc            (epc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .Instr_IF       (Instr_IF),
        .PC_IF          (PC_IF),
        .PC4_IF         (PC4_IF),
        .PC8_IF         (PC8_IF),
        .ExcCode_IF     (ExcCode_IF)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_outs(input string tag, input logic req, input logic [31:0] addr,
                              input logic [31:0] instr, input logic [31:0] pc,
                              input logic [4:0] ec, input logic cx);
        chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
        if (req) chk({tag, ".addr"}, imem_addr, addr);
        chk({tag, ".instr"}, Instr_IF, instr);
        chk({tag, ".pc"}, PC_IF, pc);
        chk({tag, ".pc4"}, PC4_IF, pc + 32'd4);
        chk({tag, ".pc8"}, PC8_IF, pc + 32'd8);
        if (cx) chk({tag, ".exc"}, {27'd0, ExcCode_IF}, {27'd0, ec});
    endtask

    typedef struct {
        logic        en, rv;
        logic [31:0] rpc;
        logic        exc, eret;
        logic [31:0] epc;
        logic        rdy;
        logic        req;
        logic [31:0] addr, instr, pc;
        logic [4:0]  ec;
        logic        cx;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic rv, input logic [31:0] rpc,
                                input logic x, input logic er, input logic [31:0] ep,
                                input logic rdy, input logic req, input logic [31:0] addr,
                                input logic [31:0] instr, input logic [31:0] pc,
                                input logic [4:0] ec, input logic cx);
        vec_t v;
        v.en = e; v.rv = rv; v.rpc = rpc; v.exc = x; v.eret = er; v.epc = ep;
        v.rdy = rdy; v.req = req; v.addr = addr; v.instr = instr; v.pc = pc;
        v.ec = ec; v.cx = cx;
        return v;
    endfunction

    vec_t tbl[28];

    // Random-phase reference state.
    logic [31:0] m_pc, m_word, m_daddr, rv_pc, e_addr, e_word, e_instr;
    logic        m_held, m_disc, rv_pend, e_req, e_vld, bad, outst;
    logic [4:0]  e_ec;

    initial begin
        // zero-wait fetch
        tbl[0]  = mk(1,0,0,0,0,0,1, 1,32'h3000,memf(32'h3000),32'h3000,0,1);
        tbl[1]  = mk(1,0,0,0,0,0,1, 1,32'h3004,memf(32'h3004),32'h3004,0,1);
        tbl[2]  = mk(1,0,0,0,0,0,1, 1,32'h3008,memf(32'h3008),32'h3008,0,1);
        // slow memory, stall when the word arrives
        tbl[3]  = mk(1,0,0,0,0,0,0, 1,32'h300C,0,32'h300C,0,1);
        tbl[4]  = mk(0,0,0,0,0,0,1, 1,32'h300C,memf(32'h300C),32'h300C,0,1);
        tbl[5]  = mk(0,0,0,0,0,0,0, 0,32'h300C,memf(32'h300C),32'h300C,0,1);
        tbl[6]  = mk(1,0,0,0,0,0,0, 0,32'h300C,memf(32'h300C),32'h300C,0,1);
        tbl[7]  = mk(1,0,0,0,0,0,1, 1,32'h3010,memf(32'h3010),32'h3010,0,1);
        // redirect held across a stall, delay slot first
        tbl[8]  = mk(1,1,32'h3100,0,0,0,0, 1,32'h3014,0,32'h3014,0,1);
        tbl[9]  = mk(0,1,32'h3100,0,0,0,1, 1,32'h3014,memf(32'h3014),32'h3014,0,1);
        tbl[10] = mk(0,1,32'h3100,0,0,0,0, 0,32'h3014,memf(32'h3014),32'h3014,0,1);
        tbl[11] = mk(0,1,32'h3100,0,0,0,0, 0,32'h3014,memf(32'h3014),32'h3014,0,1);
        tbl[12] = mk(1,1,32'h3100,0,0,0,0, 0,32'h3014,memf(32'h3014),32'h3014,0,1);
        tbl[13] = mk(1,0,0,0,0,0,1, 1,32'h3100,memf(32'h3100),32'h3100,0,1);
        tbl[14] = mk(1,0,0,0,0,0,1, 1,32'h3104,memf(32'h3104),32'h3104,0,1);
        // exception with request outstanding; stale response discarded
        tbl[15] = mk(1,0,0,0,0,0,0, 1,32'h3108,0,32'h3108,0,1);
        tbl[16] = mk(1,0,0,1,0,0,0, 1,32'h3108,0,32'h3108,0,0);
        tbl[17] = mk(1,0,0,0,0,0,0, 1,32'h3108,0,32'h4180,0,1);
        tbl[18] = mk(1,0,0,0,0,0,1, 1,32'h3108,0,32'h4180,0,1);
        tbl[19] = mk(1,0,0,0,0,0,1, 1,32'h4180,memf(32'h4180),32'h4180,0,1);
        // eret to misaligned and out-of-range addresses
        tbl[20] = mk(1,0,0,0,1,32'h3002,0, 1,32'h4184,0,32'h4184,0,0);
        tbl[21] = mk(1,0,0,0,0,0,1, 1,32'h4184,0,32'h3002,0,1);
        tbl[22] = mk(0,0,0,0,0,0,0, 0,0,0,32'h3002,5'd4,1);
        tbl[23] = mk(0,0,0,0,1,32'h5000,0, 0,0,0,32'h3002,0,0);
        tbl[24] = mk(1,0,0,0,0,0,0, 0,0,0,32'h5000,5'd4,1);
        // exc + eret + redirect together: exception wins
        tbl[25] = mk(1,1,32'h3300,1,1,32'h3200,0, 0,0,0,32'h5004,0,0);
        tbl[26] = mk(1,0,0,0,0,0,1, 1,32'h4180,memf(32'h4180),32'h4180,0,1);
        tbl[27] = mk(1,0,0,1,0,0,0, 1,32'h4184,0,32'h4184,0,0);

        // Reset state.
        repeat (2) @(posedge clk);
        #2;
        chk("rst.pc", PC_IF, T_RESET);
        chk("rst.addr", imem_addr, T_RESET);
        chk("rst.instr", Instr_IF, 32'd0);
        reset = 1'b1;
        #1;
        check_outs("rst_rel", 1'b1, T_RESET, 32'd0, T_RESET, 5'd0, 1'b1);

        for (int i = 0; i < 28; i++) begin
            @(posedge clk);
            #1;
            en = tbl[i].en; redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
            exc_req = tbl[i].exc; eret_req = tbl[i].eret; epc = tbl[i].epc;
            imem_ready = tbl[i].rdy; imem_rdata = memf(tbl[i].addr);
            #3;
            check_outs($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].instr,
                       tbl[i].pc, tbl[i].ec, tbl[i].cx);
        end

        // Async reset pulse while a stale response is being waited out.
        @(posedge clk);
        #1;
        en = 1'b1; redirect_valid = 1'b0; exc_req = 1'b0; eret_req = 1'b0; imem_ready = 1'b0;
        #1;
        check_outs("drop", 1'b1, 32'h4184, 32'd0, 32'h4180, 5'd0, 1'b1);
        reset = 1'b0;
        #1;
        check_outs("midrst", 1'b1, T_RESET, 32'd0, T_RESET, 5'd0, 1'b1);
        #1;
        reset = 1'b1;

        // Randomized run against the behavioural model.
        m_pc = T_RESET; m_held = 1'b0; m_disc = 1'b0; m_word = 32'd0; m_daddr = 32'd0;
        rv_pend = 1'b0; rv_pc = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            bad = (m_pc[1:0] != 2'b00) || (m_pc < T_LO) || (m_pc > T_HI);
            e_addr = m_pc;
            e_req = 1'b0;
            if (m_disc) begin
                e_req = 1'b1; e_addr = m_daddr;
            end else if (!m_held && !bad) begin
                e_req = 1'b1;
            end
            if (!rv_pend && ($urandom % 8 == 0)) begin
                rv_pend = 1'b1;
                if ($urandom % 8 == 0) begin
                    case ($urandom % 3)
                        0: rv_pc = 32'h0000_3001;
                        1: rv_pc = 32'h0000_2FF0;
                        default: rv_pc = 32'h0000_5000;
                    endcase
                end else begin
                    rv_pc = T_LO + ($urandom_range(0, 2047) << 2);
                end
            end
            en = ($urandom % 4) != 0;
            exc_req = ($urandom % 25) == 0;
            eret_req = ($urandom % 25) == 0;
            case ($urandom % 4)
                1: epc = 32'h0000_3002;
                2: epc = 32'h0000_5000;
                default: epc = T_LO + ($urandom_range(0, 2047) << 2);
            endcase
            redirect_valid = rv_pend;
            redirect_pc = rv_pend ? rv_pc : $urandom;
            imem_ready = e_req ? ($urandom % 2 == 1) : 1'b0;
            imem_rdata = e_req ? memf(e_addr) : $urandom;

            e_vld = 1'b0; e_word = 32'd0; e_ec = 5'd0;
            if (m_disc) begin
                e_vld = 1'b0;
            end else if (m_held) begin
                e_vld = 1'b1; e_word = m_word;
            end else if (bad) begin
                e_vld = 1'b1; e_ec = 5'd4;
            end else begin
                e_vld = imem_ready; e_word = imem_rdata;
            end
            e_instr = (exc_req || eret_req || !e_vld) ? 32'd0 : e_word;
            #3;
            check_outs("rand", e_req, e_addr, e_instr, m_pc, e_ec, !(exc_req || eret_req));

            if (exc_req || eret_req) begin
                outst = e_req && !imem_ready;
                if (outst && !m_disc) m_daddr = m_pc;
                m_disc = outst;
                m_held = 1'b0;
                m_pc = exc_req ? T_VEC : epc;
                rv_pend = 1'b0;
            end else if (m_disc) begin
                if (imem_ready) m_disc = 1'b0;
            end else if (e_vld && en) begin
                m_pc = rv_pend ? rv_pc : m_pc + 32'd4;
                rv_pend = 1'b0;
                m_held = 1'b0;
            end else if (e_vld && !m_held && !bad) begin
                m_held = 1'b1;
                m_word = imem_rdata;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
